bias_glb_reader: RTL and testbench
==================================

# bias_glb_reader

Read-side sequencer for the bias global buffer. Accepts a (base address, count) job, walks the buffer's 16-bit per-entry read port, absorbs the one-cycle synchronous read latency, and presents biases in order on a valid/ready stream toward the PE-array psum initialisation path. It sits between the layer controller and the bias GLB's narrow port, opposite the wide 64-bit loader.

## Interface
- `DATA_WIDTH`, 16: bias word width; equals GLB port-B width.
- `MEM_DEPTH`, 16: GLB entries; power of two, at least 4.
- `ADDR_WIDTH`, `$clog2(MEM_DEPTH)`: localparam.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle job request; sampled only in IDLE.
- `base_addr` in ADDR_WIDTH: first entry to read; sampled with `start`.
- `num_biases` in ADDR_WIDTH+1: entries to read, 0..MEM_DEPTH; sampled with `start`.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle pulse on completion.
- `re_b` out 1: GLB port-B read enable.
- `we_b` out 1: GLB port-B write enable; constant 0.
- `addr_b` out ADDR_WIDTH: GLB port-B address.
- `wdata_b` out DATA_WIDTH: constant 0.
- `rdata_b` in DATA_WIDTH: GLB read data, valid the cycle after `re_b`.
- `bias_out` out DATA_WIDTH: stream data.
- `bias_valid` out 1: stream valid.
- `bias_ready` in 1: stream ready from consumer.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: on `start`, latch `base_addr` into the address counter and `num_biases` into the remaining-issue counter. Go to READ, or to DONE if `num_biases`=0. `start` is ignored in every other state.
- READ: assert `re_b` with `addr_b` = address counter when issue is allowed. Issue is allowed when (buffer occupancy + in-flight read) < 2, or when a pop occurs this cycle (`bias_valid & bias_ready`). Each issue increments the address modulo MEM_DEPTH, so the walk wraps 15→0, and decrements the remaining count. Go to DRAIN when the last read issues.
- DRAIN: no reads. Go to DONE when the buffer is empty, no read is in flight, and no data remains to pop.
- DONE: `done`=1 for one cycle, then IDLE.
- In-flight flag is set on issue and cleared the following cycle. In that following cycle `rdata_b` is pushed into a 2-entry in-order FIFO.
- `bias_out`/`bias_valid` are taken from the FIFO head. Data stays stable while `bias_valid` & !`bias_ready`.
- The FIFO never overflows by construction. A push to a full FIFO is an assertion failure.
- `busy` = (state != IDLE).
- Outputs are 0 when not driven: `re_b`, `addr_b` when `re_b`=0, `bias_out` when empty.

## Timing
- Reset: state IDLE; counters, FIFO, and in-flight flag cleared. All outputs 0: `busy`, `done`, `re_b`, `addr_b`, `bias_valid`, `bias_out`.
- `rst` mid-job aborts immediately: FIFO flushed, no `done`. Any rdata returning the next cycle is discarded.
- Latency with `start` at cycle 0:
  - first `re_b` in cycle 1;
  - FIFO push at end of cycle 2;
  - `bias_valid` from cycle 3.
- With `bias_ready` held high: one bias per cycle, with no bubbles, including across address wrap.
- `done` occurs one cycle after the cycle in which the last bias is popped. `busy` falls the cycle after `done`.
- `num_biases`=0: `busy`=1 in cycle 1 (DONE) with `done`=1, and no reads.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.

## Structure
- Shared package `glb_pkg`: state enum type `rd_state_t`, plus the GLB read-latency constant (1) and FIFO depth constant (2).
- Sub-module `bias_skid_fifo`: 2-entry synchronous FIFO with push/pop/full/empty, parameterised by DATA_WIDTH. Reusable by the other GLB readers.
- Top level holds the FSM, counters, issue-credit logic, and the in-flight flag.

## Test plan
- Basic: GLB model preloaded with entry i = 0x1000+i; `start`, base 2, count 4, `bias_ready`=1 → `re_b` cycles 1–4 with addr 2,3,4,5; `bias_out` 0x1002..0x1005 in cycles 3–6; `done` in cycle 7.
- Wrap: base 14, count 4 → addr 14,15,0,1; output 0x100E,0x100F,0x1000,0x1001 with no gap.
- Backpressure: count 6; `bias_ready` low cycles 3–7, then high → occupancy never exceeds 2; `re_b` stalls; all 6 values arrive in order, each held stable while stalled.
- Zero/full count: count 0 → `done` in cycle 1, no `re_b`. Count 16 from base 5 → 16 values in wrapped order, then `done`.
- Abort: assert `rst` in cycle 4 of a count-8 job → all outputs 0 the next cycle; no `done`. A new `start` afterwards completes normally.
- Start while busy: pulse `start` with base 9 mid-job → ignored; the original sequence is unaffected.

Source files
------------

// File: rtl/glb_pkg.sv
// Shared types and constants for the global-buffer read sequencers.
package glb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } rd_state_t;

  localparam int GLB_RD_LATENCY = 1;
  localparam int FIFO_DEPTH     = 2;

endpackage

// File: rtl/bias_skid_fifo.sv
// Small in-order FIFO that absorbs the GLB read latency under stream backpressure.
module bias_skid_fifo
  import glb_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  // A pop frees a slot in the same cycle, so a full FIFO may still accept a push.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push_i && full_o && !pop_i));

endmodule

// File: rtl/bias_glb_reader.sv
// Walks the bias GLB narrow read port for a (base, count) job and streams the biases in order.
module bias_glb_reader
  import glb_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int MEM_DEPTH  = 16,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_biases,
  output logic                  busy,
  output logic                  done,
  output logic                  re_b,
  output logic                  we_b,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] wdata_b,
  input  logic [DATA_WIDTH-1:0] rdata_b,
  output logic [DATA_WIDTH-1:0] bias_out,
  output logic                  bias_valid,
  input  logic                  bias_ready
);

  rd_state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [ADDR_WIDTH:0]       rem_q, rem_d;
  logic [GLB_RD_LATENCY-1:0] inflight_q, inflight_d;
  logic                      issue, issue_ok, pop, fifo_full, fifo_empty;

  bias_skid_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q[GLB_RD_LATENCY-1]),
    .data_i  (rdata_b),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_o  (bias_out)
  );

  assign bias_valid = !fifo_empty;
  assign pop        = bias_valid && bias_ready;
  // Occupancy plus in-flight must stay below two unless a pop makes room this cycle.
  assign issue_ok   = (inflight_q[0] ? fifo_empty : !fifo_full) || pop;
  assign busy       = (state_q != IDLE);
  assign re_b       = issue;
  assign addr_b     = issue ? addr_q : '0;
  assign we_b       = 1'b0;
  assign wdata_b    = '0;
  assign inflight_d = GLB_RD_LATENCY'(issue);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    issue   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = num_biases;
          state_d = (num_biases == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (issue_ok) begin
          issue  = 1'b1;
          addr_d = addr_q + ADDR_WIDTH'(1);
          rem_d  = rem_q - (ADDR_WIDTH+1)'(1);
          if (rem_q == (ADDR_WIDTH+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // With nothing in flight, the FIFO is empty after this cycle if it is empty now or its last entry pops.
        if (!inflight_q[0] && (fifo_empty || (pop && !fifo_full))) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bias_glb_reader.sv
// Directed bench for bias_glb_reader: table of jobs plus backpressure, busy-start and abort sequences.
module tb_bias_glb_reader;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef struct {
    int          base;
    int          count;
    logic [15:0] expFirst;
    logic [15:0] expLast;
    int          expDone;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, re_b, we_b, bias_valid, bias_ready;
  logic [AW-1:0] base_addr, addr_b;
  logic [AW:0]   num_biases;
  logic [DW-1:0] wdata_b, rdata_b, bias_out;
  logic [DW-1:0] glbMem [DEPTH];
  int            checks   = 0;
  int            failures = 0;
  vec_t          vecs [6];

  bias_glb_reader #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .num_biases (num_biases),
    .busy       (busy),
    .done       (done),
    .re_b       (re_b),
    .we_b       (we_b),
    .addr_b     (addr_b),
    .wdata_b    (wdata_b),
    .rdata_b    (rdata_b),
    .bias_out   (bias_out),
    .bias_valid (bias_valid),
    .bias_ready (bias_ready)
  );

  always #5 clk = ~clk;

  // GLB model: one-cycle synchronous read, poison value when not read
  always @(posedge clk) rdata_b <= re_b ? glbMem[addr_b] : 16'hDEAD;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"},  busy, 0);
    checkOutput({tag, "_done"},  done, 0);
    checkOutput({tag, "_re_b"},  re_b, 0);
    checkOutput({tag, "_addr"},  addr_b, 0);
    checkOutput({tag, "_valid"}, bias_valid, 0);
    checkOutput({tag, "_bias"},  bias_out, 0);
  endtask

  task automatic applyStimulus(input int base, input int count, input int stallFrom, input int stallTo,
                               input int midStart, input int expDone, input bit ideal,
                               input logic [15:0] expFirst, input logic [15:0] expLast);
    int          issued, popped, doneCycle;
    bit          holding;
    logic [15:0] held, firstSeen, lastSeen;
    issued = 0; popped = 0; doneCycle = -1; holding = 0; held = '0; firstSeen = '0; lastSeen = '0;
    @(negedge clk);
    start = 1'b1; base_addr = AW'(base); num_biases = (AW+1)'(count); bias_ready = 1'b1;
    for (int cyc = 1; cyc <= count + 40 && doneCycle < 0; cyc++) begin
      @(negedge clk);
      start      = (cyc == midStart);
      base_addr  = (cyc == midStart) ? 4'd9 : AW'(base);
      num_biases = (cyc == midStart) ? 5'd3 : (AW+1)'(count);
      bias_ready = !(cyc >= stallFrom && cyc <= stallTo);
      #1;
      checkOutput("busy_in_job", busy, 1);
      checkOutput("we_b", {we_b, wdata_b}, 0);
      checkOutput("outstanding_le_2", (issued - popped) <= 2, 1);
      if (ideal) begin
        checkOutput("re_b_timing", re_b, (cyc >= 1 && cyc <= count));
        checkOutput("valid_timing", bias_valid, (cyc >= 3 && cyc <= count + 2));
      end
      if (stallFrom >= 3 && cyc >= stallFrom && cyc <= stallTo) checkOutput("re_b_stall", re_b, 0);
      if (re_b) begin
        checkOutput("addr_b", addr_b, (base + issued) % DEPTH);
        issued++;
      end else begin
        checkOutput("addr_idle", addr_b, 0);
      end
      if (holding) checkOutput("hold_stable", {bias_valid, bias_out}, {1'b1, held});
      if (!bias_valid) checkOutput("bias_out_idle", bias_out, 0);
      if (bias_valid && bias_ready) begin
        checkOutput("bias_data", bias_out, 16'h1000 + ((base + popped) % DEPTH));
        if (popped == 0) firstSeen = bias_out;
        lastSeen = bias_out;
        popped++;
      end
      holding = bias_valid && !bias_ready;
      held    = bias_out;
      if (done) doneCycle = cyc;
    end
    checkOutput("done_cycle", doneCycle, expDone);
    checkOutput("issued_total", issued, count);
    checkOutput("popped_total", popped, count);
    if (count > 0) begin
      checkOutput("first_bias", firstSeen, expFirst);
      checkOutput("last_bias", lastSeen, expLast);
    end
    start = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("done_pulse_end", done, 0);
    checkOutput("busy_after_done", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) glbMem[i] = 16'h1000 + 16'(i);
    vecs[0] = '{base: 2,  count: 4,  expFirst: 16'h1002, expLast: 16'h1005, expDone: 7};
    vecs[1] = '{base: 14, count: 4,  expFirst: 16'h100E, expLast: 16'h1001, expDone: 7};
    vecs[2] = '{base: 5,  count: 16, expFirst: 16'h1005, expLast: 16'h1004, expDone: 19};
    vecs[3] = '{base: 0,  count: 0,  expFirst: 16'h0000, expLast: 16'h0000, expDone: 1};
    vecs[4] = '{base: 15, count: 1,  expFirst: 16'h100F, expLast: 16'h100F, expDone: 4};
    vecs[5] = '{base: 7,  count: 2,  expFirst: 16'h1007, expLast: 16'h1008, expDone: 5};

    rst = 1'b1; start = 1'b0; base_addr = '0; num_biases = '0; bias_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 6; v++)
      applyStimulus(vecs[v].base, vecs[v].count, 0, -1, 0, vecs[v].expDone, 1'b1,
                    vecs[v].expFirst, vecs[v].expLast);

    // Backpressure: ready low in cycles 3..7
    applyStimulus(2, 6, 3, 7, 0, 14, 1'b0, 16'h1002, 16'h1007);

    // Start pulse with base 9 in cycle 4 of a running job must be ignored
    applyStimulus(2, 6, 0, -1, 4, 9, 1'b1, 16'h1002, 16'h1007);

    // Abort: reset in cycle 4 of a count-8 job
    @(negedge clk);
    start = 1'b1; base_addr = 4'd0; num_biases = 5'd8; bias_ready = 1'b1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkAllZero("abort");
    rst = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      #1;
      checkOutput("abort_no_done", done, 0);
      checkOutput("abort_no_valid", bias_valid, 0);
      checkOutput("abort_no_read", re_b, 0);
    end
    applyStimulus(3, 3, 0, -1, 0, 6, 1'b1, 16'h1003, 16'h1005);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
